// File: rtl/pp_gen_array.sv
// Per-lane partial-product generator: decodes image/weight fields into {sign,1,mant} plus
// an exponent sum, with a two-stage valid/ready pipeline and a saturating zero-product counter.
module pp_gen_array #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned EXP_W  = 4,
    parameter int unsigned MANT_W = 3,
    parameter int unsigned WEXP_W = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*(1+EXP_W+MANT_W)-1:0] image,
    input  logic [LANES*(1+WEXP_W)-1:0]   weight,
    input  logic                          cnt_clr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*(MANT_W+2)-1:0]   signed_pp,
    output logic [LANES*(EXP_W+1)-1:0]    exp,
    output logic [LANES-1:0]              zero,
    output logic [CNT_W-1:0]              zero_cnt
);
    localparam int unsigned IW   = 1 + EXP_W + MANT_W;
    localparam int unsigned WW   = 1 + WEXP_W;
    localparam int unsigned PW   = MANT_W + 2;
    localparam int unsigned XW   = EXP_W + 1;
    localparam int unsigned PC_W = $clog2(LANES + 1);
    localparam int unsigned SW   = CNT_W + PC_W;

    generate
        if (WEXP_W > EXP_W) begin : g_bad_wexp
            $error("pp_gen_array: WEXP_W must not exceed EXP_W");
        end
    endgenerate

    logic                      s1_valid;
    logic [LANES-1:0]          s1_zero;
    logic [LANES-1:0]          s1_sign;
    logic [LANES*MANT_W-1:0]   s1_mant;
    logic [LANES*XW-1:0]       s1_exp;

    logic [LANES-1:0]          d_zero;
    logic [LANES-1:0]          d_sign;
    logic [LANES*MANT_W-1:0]   d_mant;
    logic [LANES*XW-1:0]       d_exp;
    logic [LANES*PW-1:0]       pp_next;
    logic [PC_W-1:0]           pop;
    logic [SW-1:0]             cnt_sum;
    logic [CNT_W-1:0]          cnt_sat;
    logic                      s2_adv;
    logic                      out_xfer;

    // S2 can take a beat when empty or draining this cycle; S1 likewise behind it.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign out_xfer = out_valid && out_ready;

    // Lane decode: zero detection, sign, exponent sum.
    always_comb begin
        d_zero = '0;
        d_sign = '0;
        d_mant = '0;
        d_exp  = '0;
        for (int i = 0; i < LANES; i++) begin
            d_zero[i] = ((image[i*IW + MANT_W +: EXP_W] == '0) && (image[i*IW +: MANT_W] == '0))
                        || (&weight[i*WW +: WEXP_W]);
            d_sign[i] = !d_zero[i] && (image[i*IW + IW - 1] ^ weight[i*WW + WEXP_W]);
            d_mant[i*MANT_W +: MANT_W] = image[i*IW +: MANT_W];
            d_exp[i*XW +: XW] = d_zero[i] ? '0
                              : XW'(image[i*IW + MANT_W +: EXP_W]) + XW'(weight[i*WW +: WEXP_W]);
        end
    end

    // Output formatting from S1 fields; zero lanes collapse to all-zero.
    always_comb begin
        pp_next = '0;
        for (int i = 0; i < LANES; i++) begin
            pp_next[i*PW +: PW] = s1_zero[i] ? '0
                                : {s1_sign[i], 1'b1, s1_mant[i*MANT_W +: MANT_W]};
        end
    end

    // Saturating accumulate of zero lanes on the beat leaving S2.
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + PC_W'(zero[i]);
        end
        cnt_sum = SW'(zero_cnt) + SW'(pop);
        cnt_sat = (cnt_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_zero   <= '0;
            s1_sign   <= '0;
            s1_mant   <= '0;
            s1_exp    <= '0;
            out_valid <= 1'b0;
            signed_pp <= '0;
            exp       <= '0;
            zero      <= '0;
            zero_cnt  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_zero <= d_zero;
                    s1_sign <= d_sign;
                    s1_mant <= d_mant;
                    s1_exp  <= d_exp;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    signed_pp <= pp_next;
                    exp       <= s1_exp;
                    zero      <= s1_zero;
                end
            end
            // Clear has priority over a coincident output transfer.
            if (cnt_clr) begin
                zero_cnt <= '0;
            end else if (out_xfer) begin
                zero_cnt <= cnt_sat;
            end
        end
    end
endmodule

// File: tb/tb_pp_gen_array.sv
// Scoreboard bench for pp_gen_array: directed beats queue hand-computed results,
// a negedge monitor checks every presented beat and tracks the zero counter.
module tb_pp_gen_array;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic [19:0] pp;
        logic [19:0] ex;
        logic [3:0]  z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] image;
    logic [15:0] weight;
    logic        cnt_clr;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] signed_pp;
    logic [19:0] exp;
    logic [3:0]  zero;
    logic [3:0]  zero_cnt;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cnt_model = 0;
    bit   saw_block = 1'b0;

    pp_gen_array #(.LANES(4), .EXP_W(4), .MANT_W(3), .WEXP_W(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .image(image), .weight(weight), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .signed_pp(signed_pp), .exp(exp), .zero(zero), .zero_cnt(zero_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one beat; the expected result is queued on the edge that accepts it.
    task automatic send(input logic [31:0] img, input logic [15:0] wt,
                        input logic [19:0] pp, input logic [19:0] ex, input logic [3:0] z);
        exp_t e;
        bit   done;
        e.pp = pp; e.ex = ex; e.z = z;
        in_valid = 1'b1; image = img; weight = wt;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            failures++;
            $display("FAIL send_timeout: in_ready stuck low, beat not accepted");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compare any presented beat with the queue head, pop on transfer.
    always @(negedge clk) begin
        exp_t e;
        int   s;
        bit   popped;
        popped = 1'b0;
        if (rst) begin
            cnt_model = 0;
        end else begin
            check("zero_cnt", 32'(zero_cnt), 32'(cnt_model));
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat: pp=%h exp=%h zero=%b with empty queue", signed_pp, exp, zero);
                end else begin
                    e = sb[0];
                    checks++;
                    if (signed_pp !== e.pp || exp !== e.ex || zero !== e.z) begin
                        failures++;
                        $display("FAIL beat: got pp=%h exp=%h zero=%b expected pp=%h exp=%h zero=%b",
                                 signed_pp, exp, zero, e.pp, e.ex, e.z);
                    end
                    if (out_ready) begin
                        void'(sb.pop_front());
                        popped = 1'b1;
                    end
                end
            end
            if (cnt_clr) begin
                cnt_model = 0;
            end else if (popped) begin
                s = cnt_model + $countones(e.z);
                cnt_model = (s > CNT_MAX) ? CNT_MAX : s;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; image = '0; weight = '0; cnt_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_zero_cnt", 32'(zero_cnt), 32'd0);
        check("rst_outputs", {signed_pp[11:0], exp[15:0], zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Sign/exponent decode: 0x55 x 0xA gives {1,1,101}, exp 10+2.
        send({4{8'h55}}, {4{4'hA}}, {4{5'b11101}}, {4{5'd12}}, 4'b0000);
        // Lane1 zero image, lane2 all-ones wexp.
        send({8'h55, 8'h55, 8'h00, 8'h55}, {4'hA, 4'h7, 4'hA, 4'hA},
             {5'b11101, 5'b00000, 5'b00000, 5'b11101}, {5'd12, 5'd0, 5'd0, 5'd12}, 4'b0110);
        // Max exponent: 15 + 6 = 21.
        send({4{8'h7F}}, {4{4'h6}}, {4{5'b01111}}, {4{5'd21}}, 4'b0000);
        // Negative x negative: sign 0, exp 9+1.
        send({4{8'hC9}}, {4{4'h9}}, {4{5'b01001}}, {4{5'd10}}, 4'b0000);
        // Negative zero image: sign forced 0.
        send({4{8'h80}}, {4{4'h1}}, 20'd0, 20'd0, 4'b1111);
        // Zero exponent with nonzero mantissa is not a zero product.
        send({4{8'h03}}, {4{4'h0}}, {4{5'b01011}}, 20'd0, 4'b0000);
        // Negative all-ones wexp is zero.
        send({4{8'h55}}, {4{4'hF}}, 20'd0, 20'd0, 4'b1111);
        in_valid = 1'b0;
        drain();
        check("cnt_after_directed", 32'(zero_cnt), 32'd10);

        // Six back-to-back beats with out_ready low for three cycles.
        fork
            begin
                send({4{8'h55}}, {4{4'hA}}, {4{5'b11101}}, {4{5'd12}}, 4'b0000);
                send({8'h55, 8'h55, 8'h00, 8'h55}, {4'hA, 4'h7, 4'hA, 4'hA},
                     {5'b11101, 5'b00000, 5'b00000, 5'b11101}, {5'd12, 5'd0, 5'd0, 5'd12}, 4'b0110);
                send({4{8'h7F}}, {4{4'h6}}, {4{5'b01111}}, {4{5'd21}}, 4'b0000);
                send({4{8'hC9}}, {4{4'h9}}, {4{5'b01001}}, {4{5'd10}}, 4'b0000);
                send({4{8'h80}}, {4{4'h1}}, 20'd0, 20'd0, 4'b1111);
                send({4{8'h03}}, {4{4'h0}}, {4{5'b01011}}, 20'd0, 4'b0000);
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_backpressure", 32'(saw_block), 32'd1);

        // Saturation: clear, then 5 all-zero beats (20 zero lanes) clamp at 15.
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("cnt_clear", 32'(zero_cnt), 32'd0);
        for (int b = 0; b < 5; b++) send(32'd0, 16'd0, 20'd0, 20'd0, 4'b1111);
        in_valid = 1'b0;
        drain();
        check("cnt_saturate", 32'(zero_cnt), 32'd15);

        // Clear coincident with a zero-beat transfer: clear wins.
        send(32'd0, 16'd0, 20'd0, 20'd0, 4'b1111);
        in_valid = 1'b0;
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("clr_vs_xfer", 32'(zero_cnt), 32'd0);
        check("clr_vs_xfer_q", 32'(sb.size()), 32'd0);

        // Build a nonzero count, then reset with two beats in flight.
        send({8'h55, 8'h55, 8'h00, 8'h55}, {4'hA, 4'h7, 4'hA, 4'hA},
             {5'b11101, 5'b00000, 5'b00000, 5'b11101}, {5'd12, 5'd0, 5'd0, 5'd12}, 4'b0110);
        in_valid = 1'b0;
        drain();
        check("cnt_pre_reset", 32'(zero_cnt), 32'd2);
        send({4{8'h55}}, {4{4'hA}}, {4{5'b11101}}, {4{5'd12}}, 4'b0000);
        send({4{8'h7F}}, {4{4'h6}}, {4{5'b01111}}, {4{5'd21}}, 4'b0000);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_zero_cnt", 32'(zero_cnt), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // First beat after reset: invisible after one edge, presented after two.
        send({4{8'h7F}}, {4{4'h6}}, {4{5'b01111}}, {4{5'd21}}, 4'b0000);
        in_valid = 1'b0;
        check("lat_stage1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_stage2", 32'(out_valid), 32'd1);
        check("lat_pp", 32'(signed_pp), 32'({4{5'b01111}}));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
